// File: rtl/gcd_pkg.sv
// gcd_pkg: shared state encoding and algorithm-select constants for the GCD engine
package gcd_pkg;
    typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;
    localparam logic MODE_SUB = 1'b0;
    localparam logic MODE_BIN = 1'b1;
endpackage

// File: rtl/gcd_if.sv
// gcd_if: start/ready/done handshake, operands and results of the GCD engine
//   master drives start, a_in, b_in, mode; slave drives ready, done, result, zero_op, iter_count
interface gcd_if #(parameter int WIDTH = 16, parameter int ITER_W = WIDTH + 1);
    logic              start;
    logic              mode;
    logic [WIDTH-1:0]  a_in;
    logic [WIDTH-1:0]  b_in;
    logic              ready;
    logic              done;
    logic              zero_op;
    logic [WIDTH-1:0]  result;
    logic [ITER_W-1:0] iter_count;
    modport master(output start, mode, a_in, b_in, input ready, done, zero_op, result, iter_count);
    modport slave(input start, mode, a_in, b_in, output ready, done, zero_op, result, iter_count);
endinterface

// File: rtl/gcd_step.sv
// gcd_step: one combinational update step of the subtractive or binary GCD
//   a, b, k, mode in; a_nx, b_nx, k_nx, eq out
module gcd_step
    import gcd_pkg::*;
#(
    parameter int WIDTH = 16,
    parameter int K_W   = $clog2(WIDTH) + 1
) (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [K_W-1:0]   k,
    input  logic             mode,
    output logic [WIDTH-1:0] a_nx,
    output logic [WIDTH-1:0] b_nx,
    output logic [K_W-1:0]   k_nx,
    output logic             eq
);
    logic bin, gt;
    logic [WIDTH-1:0] sub_a, sub_b;
    always_comb begin
        bin   = mode == MODE_BIN;
        gt    = a > b;
        eq    = a == b;
        sub_a = gt ? a - b : a;
        sub_b = gt ? b : b - a;
        // an even operand is always halved first; the other one waits
        a_nx  = bin && !a[0] ? a >> 1 : bin && !b[0] ? a : sub_a;
        b_nx  = bin && !b[0] ? b >> 1 : bin && !a[0] ? b : sub_b;
        k_nx  = bin && !a[0] && !b[0] ? k + K_W'(1) : k;
    end
endmodule

// File: rtl/gcd_unit.sv
// gcd_unit: multi-cycle GCD engine with selectable subtractive/binary algorithm
//   clk, rst (sync, active-high); bus (gcd_if.slave): start/a_in/b_in/mode in,
//   ready/done/result/zero_op/iter_count out, all outputs registered
module gcd_unit
    import gcd_pkg::*;
#(
    parameter int WIDTH  = 16,
    parameter int ITER_W = WIDTH + 1,
    parameter int K_W    = $clog2(WIDTH) + 1
) (
    input logic  clk,
    input logic  rst,
    gcd_if.slave bus
);
    state_t state, state_nx;
    logic [WIDTH-1:0]  a_r, b_r, a_nx, b_nx, result_r;
    logic [K_W-1:0]    k_r, k_nx;
    logic [ITER_W-1:0] iter_r;
    logic              mode_r, zero_r, eq, accept, zero_in;

    gcd_step #(.WIDTH(WIDTH), .K_W(K_W)) u_step (
        .a(a_r), .b(b_r), .k(k_r), .mode(mode_r),
        .a_nx(a_nx), .b_nx(b_nx), .k_nx(k_nx), .eq(eq)
    );

    always_comb begin
        accept   = bus.start && state != RUN;
        zero_in  = bus.a_in == '0 || bus.b_in == '0;
        state_nx = accept ? (zero_in ? DONE : RUN) : state == RUN && eq ? DONE : state;
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            a_r      <= '0;
            b_r      <= '0;
            k_r      <= '0;
            mode_r   <= MODE_SUB;
            iter_r   <= '0;
            result_r <= '0;
            zero_r   <= 1'b0;
        end else if (accept) begin
            iter_r <= '0;
            zero_r <= zero_in;
            if (zero_in) result_r <= bus.a_in | bus.b_in;
            else begin
                a_r    <= bus.a_in;
                b_r    <= bus.b_in;
                k_r    <= '0;
                mode_r <= bus.mode;
            end
        end else if (state == RUN) begin
            if (eq) result_r <= mode_r == MODE_BIN ? a_r << k_r : a_r;
            else begin
                a_r    <= a_nx;
                b_r    <= b_nx;
                k_r    <= k_nx;
                iter_r <= &iter_r ? iter_r : iter_r + ITER_W'(1);
            end
        end
    end

    assign bus.ready      = state != RUN;
    assign bus.done       = state == DONE;
    assign bus.result     = result_r;
    assign bus.zero_op    = zero_r;
    assign bus.iter_count = iter_r;
endmodule

// File: doc/gcd_unit.md
Name: gcd_unit

Overview:
- Parametrised GCD engine. Successor to the fixed 16-bit subtract-only GCD datapath/controller pair.
- Adds a generic operand width, a runtime-selectable algorithm (repeated subtraction or binary/Stein), a ready/start/done handshake, synchronous reset, zero-operand handling and an iteration counter.
- Sits as a compute slave behind a bus-facing register block; one operation in flight at a time.

Parameters:
- WIDTH, 16, operand and result width in bits (>=2).
- ITER_W, WIDTH+1, width of the iteration counter; the counter saturates at all-ones.
- K_W, $clog2(WIDTH)+1, width of the binary-mode common-power-of-two counter.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset. Synchronous, active-high.
- start  in  1  request. Accepted only on a clk edge where ready=1.
- a_in  in  WIDTH  operand A. Sampled on the accept edge.
- b_in  in  WIDTH  operand B. Sampled on the accept edge.
- mode  in  1  algorithm select: 0 = subtractive, 1 = binary (Stein). Sampled on the accept edge.
- ready  out  1  high in IDLE and DONE; unit can accept start.
- done  out  1  high while in DONE; result valid.
- result  out  WIDTH  GCD. Held until the next accept.
- zero_op  out  1  an operand was zero at accept. Held with result.
- iter_count  out  ITER_W  number of update steps taken, excluding the final equality cycle and zero-operand handling. Held with result.

Behaviour:
- Reset: on an rst edge, state=IDLE and ready=1. done, result, zero_op, iter_count, internal A, B and k all go to 0. rst wins over start on the same edge. rst mid-RUN aborts with no done.
- States: IDLE, RUN, DONE. Binary encoding comes from the package.
- IDLE/DONE with start=1, both operands nonzero: A<=a_in, B<=b_in, mode latched, k<=0, iter<=0, done<=0, zero_op<=0. Go to RUN.
- IDLE/DONE with start=1, a_in==0 or b_in==0: go directly to DONE. result<=a_in|b_in, zero_op<=1, iter<=0. gcd(0,0) therefore gives 0 with zero_op=1.
- start with ready=0 (RUN) is ignored; no queueing.
- RUN, subtractive mode, one step per cycle:
  - A>B: A<=A-B.
  - B>A: B<=B-A.
  - A==B: go to DONE, result<=A.
- RUN, binary mode, first matching rule per cycle:
  - A==B: go to DONE, result<=A<<k.
  - A and B both even: A>>=1, B>>=1, k++.
  - A even: A>>=1.
  - B even: B>>=1.
  - A>B: A<=A-B.
  - Otherwise: B<=B-A.
- Every non-terminal RUN cycle increments iter, saturating at 2^ITER_W-1.
- Arithmetic: all unsigned WIDTH-bit. Subtraction never underflows because it is guarded by the comparison. k never exceeds WIDTH-1, and result<<k never overflows because the result is <= min(a_in,b_in).
- Latency from accept edge to done high is iter_count+2 edges: the accept edge, iter_count update edges, then the equality edge. The zero-operand path takes 1 edge.
- DONE: done=1 and ready=1. Outputs hold indefinitely. A new start on a DONE edge clears done on that same edge, so back-to-back operations need no IDLE cycle.
- No combinational path from inputs to outputs. All outputs are registered.

Decomposition:
- Package gcd_pkg:
  - state enum (IDLE, RUN, DONE);
  - mode constants MODE_SUB=0 and MODE_BIN=1.
- One sub-module, gcd_step (combinational). Inputs: A, B, k, mode. Outputs: next A, next B, next k, and an eq flag.
- gcd_unit holds the FSM, registers, counter and handshake.

Test Plan:
- Reset, then start a=48, b=18, mode=0 -> done after 6 edges; result=6, iter_count=4, zero_op=0.
- a=48, b=18, mode=1 -> done after 8 edges; result=6, iter_count=6, with internal k=1.
- a=0, b=35, either mode -> next edge done=1, result=35, zero_op=1, iter_count=0. Repeat with a=0, b=0 -> result=0, zero_op=1.
- WIDTH=16, a=65535, b=1, mode=0 -> result=1, iter_count=65534. Same operands with mode=1 -> result=1 in far fewer steps.
- Pulse start mid-RUN with other operands -> ignored, and the original result is produced. Then start on the DONE cycle -> done drops on that edge and the new operation runs.
- Assert rst for one edge mid-RUN -> ready=1, done=0, result=0, iter_count=0. A subsequent start a=21, b=14 gives result=7.
